// File: rtl/comparador_pkg.sv
// comparador_pkg: shared types and helpers for the bit-serial magnitude
// comparator (comparador_serial) and its 1-bit compare cell.
package comparador_pkg;

   // Controller states: waiting, scanning one bit per cycle, presenting result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of the bit-index counter: clog2(width), never below 1 bit.
   function automatic int idx_w(input int width);
      int w;
      w = $clog2(width);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/comparador_bit.sv
// comparador_bit: combinational 1-bit magnitude cell. At the sign position
// of a two's-complement operand a set bit means "smaller", so the sense of
// the comparison is swapped there.
module comparador_bit (
   input  logic a_bit,
   input  logic b_bit,
   input  logic sign_pos,
   output logic bit_gt,
   output logic bit_lt
);

   logic raw_gt;
   logic raw_lt;

   assign raw_gt = a_bit & ~b_bit;
   assign raw_lt = ~a_bit & b_bit;

   // Swap the sense only at the sign bit.
   assign bit_gt = sign_pos ? raw_lt : raw_gt;
   assign bit_lt = sign_pos ? raw_gt : raw_lt;

endmodule

// File: rtl/comparador_serial.sv
// comparador_serial: clocked MSB-first bit-serial magnitude comparator with
// start/done handshake and early exit on the first differing bit.
// Optional build macro COMPARADOR_SIGNED_EN: treat operands as two's
// complement (sign bit compared with inverted sense). Undefined: unsigned.
module comparador_serial
   import comparador_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   localparam int IW = idx_w(WIDTH);
   localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [IW-1:0]    idx;

   logic sign_pos;
   logic bit_gt;
   logic bit_lt;

`ifdef COMPARADOR_SIGNED_EN
   // Only the MSB carries the sign.
   assign sign_pos = (idx == IDX_MSB);
`else
   assign sign_pos = 1'b0;
`endif

   comparador_bit u_bit (
      .a_bit    (ra[idx]),
      .b_bit    (rb[idx]),
      .sign_pos (sign_pos),
      .bit_gt   (bit_gt),
      .bit_lt   (bit_lt)
   );

   // Controller, index counter and registered outputs in one sequential block.
   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge value of the others, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ra    <= '0;
         rb    <= '0;
         idx   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         gt    <= 1'b0;
         eq    <= 1'b0;
         lt    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               // done is a single-cycle pulse; results hold until next accept.
               done <= 1'b0;
               if (start) begin
                  ra    <= a;
                  rb    <= b;
                  idx   <= IDX_MSB;
                  gt    <= 1'b0;
                  eq    <= 1'b0;
                  lt    <= 1'b0;
                  busy  <= 1'b1;
                  state <= SCAN;
               end else begin
                  state <= IDLE;
               end
            end
            SCAN: begin
               if (bit_gt || bit_lt) begin
                  gt    <= bit_gt;
                  lt    <= bit_lt;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end else if (idx == '0) begin
                  eq    <= 1'b1;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/comparador_serial.md
# comparador_serial

Parametrised, clocked magnitude comparator and successor to the 2-bit combinational comparator. It compares two WIDTH-bit operands bit-serially from MSB to LSB under a start/done handshake, and exits early at the first differing bit. Results are registered and held. It sits in the lab datapath wherever operands wider than 2 bits must be ordered without a wide combinational compare tree.

## Interface
Parameters:
- WIDTH, 8, operand width in bits.
  - Minimum 1 unsigned; minimum 2 when COMPARADOR_SIGNED_EN is defined.

Ports:
- clk  input  1  single clock; rising edge active.
- rst  input  1  reset, asynchronous and active-high; clears all state immediately.
- start  input  1  request a compare; accepted only in IDLE or DONE.
- a  input  WIDTH  operand A; sampled only on the accepting edge.
- b  input  WIDTH  operand B; sampled only on the accepting edge.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse; results are valid in that cycle.
- gt  output  1  A > B.
- eq  output  1  A == B.
- lt  output  1  A < B.

## Operation
- States:
  - IDLE: waiting for start.
  - SCAN: examining one bit per cycle.
  - DONE: one-cycle result presentation.
- IDLE/DONE with start=1 at a clock edge:
  - Latch a, b into internal registers.
  - Set idx = WIDTH-1.
  - Clear gt/eq/lt to 0.
  - Go to SCAN.
- IDLE/DONE with start=0: go to (or stay in) IDLE.
- SCAN, at each edge, compare ra[idx] with rb[idx]:
  - Bits differ: set gt (ra bit = 1) or lt (rb bit = 1); go to DONE.
  - Bits equal and idx == 0: set eq; go to DONE.
  - Otherwise: decrement idx; stay in SCAN.
- start is ignored in SCAN. Inputs a and b are don't-care outside the accepting edge.
- Exactly one of gt/eq/lt is high from the edge entering DONE until the next accepted start or reset.
- idx width is clog2(WIDTH), minimum 1. idx never wraps below 0.

## Timing
- Reset values: state IDLE; busy, done, gt, eq, lt all 0; idx and operand registers 0.
- Latency: with start accepted at edge E0 and the first differing bit being the k-th examined (k = 1..WIDTH), results and done appear after edge Ek.
  - Equal operands take k = WIDTH.
- done is high for exactly one cycle. busy is high from after E0 until the edge entering DONE.
- Back-to-back operation: start held high during DONE starts the next compare at that edge.
  - done still pulses for the finishing operation.
  - Results clear at the same edge.
  - Maximum throughput is one result per k+1 cycles.
- Reset mid-SCAN aborts the operation with no done pulse. All outputs return to 0 asynchronously.
- Outputs are registered; there are no combinational paths from input to output.

## Configuration
- COMPARADOR_SIGNED_EN:
  - Defined: operands are two's complement. At idx = WIDTH-1 only, the sense is inverted: ra bit 1 with rb bit 0 sets lt; the opposite sets gt. Lower bits compare as unsigned. Latency is unchanged.
  - Undefined: purely unsigned comparison.

## Structure
- Package comparador_pkg holds:
  - the state typedef (IDLE, SCAN, DONE);
  - helper function idx_w(WIDTH) = max(1, clog2(WIDTH)).
- One sub-module, comparador_bit: combinational 1-bit cell.
  - Inputs: a_bit, b_bit, sign_pos.
  - Outputs: bit_gt, bit_lt.
  - sign_pos is tied to (idx == WIDTH-1) only when COMPARADOR_SIGNED_EN is defined.
- The FSM, index counter and result registers live in the top module.

## Test plan
All scenarios use WIDTH = 8.
- Reset while idle:
  - Stimulus: rst high; release rst.
  - Required: busy, done, gt, eq, lt all 0.
  - Stimulus: start pulse with a = 8'h00, b = 8'h00.
  - Required: eq = 1 and a done pulse 8 cycles after the accepting edge.
- Early exit:
  - Stimulus: a = 8'h80, b = 8'h7F.
  - Required: gt = 1, done 1 cycle after start, busy high for 1 cycle.
  - Stimulus: a = 8'h12, b = 8'h13.
  - Required: lt = 1, done after 8 cycles.
- Back-to-back:
  - Stimulus: hold start = 1 continuously with a = 8'h40, b = 8'h00.
  - Required: gt = 1 and done every 3rd cycle (2 cycles SCAN, 1 cycle DONE/restart). Results clear on each accept.
- Reset mid-operation:
  - Stimulus: a = b = 8'hAA; assert rst at cycle 4 of SCAN.
  - Required: all outputs drop to 0 asynchronously; no done pulse.
  - Stimulus: a new start after reset.
  - Required: completes normally.
- start during SCAN:
  - Stimulus: pulse start mid-scan with different operands.
  - Required: ignored; the original result and latency are unchanged.
- Signed mode (COMPARADOR_SIGNED_EN defined):
  - Stimulus: a = 8'hFF (-1), b = 8'h01.
  - Required: lt = 1 after 1 cycle.
  - Stimulus: a = 8'h80, b = 8'h80.
  - Required: eq = 1 after 8 cycles.
  - Undefined: a = 8'hFF, b = 8'h01 gives gt = 1.
